// File: rtl/vc_cleaner.sv
// vc_cleaner
// Reduces a raw virtual-channel select vector to a clean one-hot (or all-zero) vector.
// The lowest-index set bit wins. All outputs are registered, so latency is one clock.
//
// Ports:
//   clk    system clock, rising-edge active
//   rst_n  asynchronous active-low reset
//   in1    raw VC vector; bit i high means VC i is requested or flagged
//   out1   registered cleaned vector, one-hot or all-zero
//   multi  registered flag: the sampled in1 had two or more bits set
//   none   registered flag: the sampled in1 was all-zero
module vc_cleaner #(
    parameter int unsigned VC_NUM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [VC_NUM-1:0] in1,
    output logic [VC_NUM-1:0] out1,
    output logic              multi,
    output logic              none
);

    logic [VC_NUM-1:0] out1_d;
    logic              multi_d;
    logic              none_d;
    logic              seen;

    // Priority chain from bit 0 upward. 'seen' records that some lower bit was
    // already set: the first set bit is kept, and any later set bit means the
    // input had at least two bits set.
    always_comb begin
        out1_d  = '0;
        multi_d = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < int'(VC_NUM); k++) begin
            if (in1[k]) begin
                if (seen) begin
                    multi_d = 1'b1;
                end else begin
                    out1_d[k] = 1'b1;
                end
                seen = 1'b1;
            end
        end
        none_d = ~seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1  <= '0;
            multi <= 1'b0;
            none  <= 1'b1;
        end else begin
            out1  <= out1_d;
            multi <= multi_d;
            none  <= none_d;
        end
    end

endmodule

// File: tb/tb_vc_cleaner.sv
// Self-checking bench for vc_cleaner at VC_NUM = 8 and VC_NUM = 4.
module tb_vc_cleaner;

    logic       clk;
    logic       rst_n;
    logic [7:0] in8;
    logic [7:0] out8;
    logic       multi8;
    logic       none8;
    logic [3:0] in4;
    logic [3:0] out4;
    logic       multi4;
    logic       none4;

    int n_checks = 0;
    int n_errors = 0;

    vc_cleaner #(.VC_NUM(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in8),
        .out1  (out8),
        .multi (multi8),
        .none  (none8)
    );

    vc_cleaner #(.VC_NUM(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .in1   (in4),
        .out1  (out4),
        .multi (multi4),
        .none  (none4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: isolate lowest set bit arithmetically, count bits for flags.
    function automatic logic [7:0] ref_lsb8(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

    function automatic logic [3:0] ref_lsb4(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, ".out8"},   32'(out8),   32'h0);
        check({tag, ".multi8"}, 32'(multi8), 32'h0);
        check({tag, ".none8"},  32'(none8),  32'h1);
        check({tag, ".out4"},   32'(out4),   32'h0);
        check({tag, ".none4"},  32'(none4),  32'h1);
    endtask

    // Drive one vector per cycle (at negedge) and check the result just after the
    // following rising edge, so consecutive calls exercise back-to-back edges.
    task automatic apply8(input string tag, input logic [7:0] v);
        @(negedge clk);
        in8 = v;
        @(posedge clk);
        #1;
        check({tag, ".out1"},  32'(out8),   32'(ref_lsb8(v)));
        check({tag, ".multi"}, 32'(multi8), 32'($countones(v) >= 2));
        check({tag, ".none"},  32'(none8),  32'(v == 8'h00));
    endtask

    task automatic apply4(input string tag, input logic [3:0] v);
        @(negedge clk);
        in4 = v;
        @(posedge clk);
        #1;
        check({tag, ".out1"},  32'(out4),   32'(ref_lsb4(v)));
        check({tag, ".multi"}, 32'(multi4), 32'($countones(v) >= 2));
        check({tag, ".none"},  32'(none4),  32'(v == 4'h0));
    endtask

    initial begin
        logic [7:0] seq [7];
        logic [7:0] exp_seq [7];
        seq     = '{8'h00, 8'h01, 8'h02, 8'h84, 8'h02, 8'h01, 8'h80};
        exp_seq = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h02, 8'h01, 8'h80};

        rst_n = 1'b0;
        in8   = 8'hFF;
        in4   = 4'hF;

        // Held reset with all-ones input and clocks running.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single-bit and zero inputs.
        apply8("zero", 8'h00);
        apply8("b0", 8'h01);
        apply8("b1", 8'h02);
        apply8("msb", 8'h80);

        // Multi-bit inputs.
        apply8("multi84", 8'b1000_0100);
        check("multi84.lit", 32'(out8), 32'h04);
        apply8("ones", 8'hFF);
        check("ones.lit", 32'(out8), 32'h01);

        // Back-to-back sequence against literal expectations.
        for (int i = 0; i < 7; i++) begin
            apply8("seq", seq[i]);
            check("seq.lit", 32'(out8), 32'(exp_seq[i]));
        end

        // Asynchronous reset mid-cycle after activity.
        apply8("pre_rst", 8'h6C);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        @(posedge clk);
        #1;
        check_reset_vals("rst_low_edge");
        @(negedge clk);
        rst_n = 1'b1;
        apply8("post_rst", 8'h30);

        // Exhaustive sweep.
        for (int v = 0; v < 256; v++) begin
            apply8("sweep", 8'(v));
        end

        // Randomized vectors.
        for (int i = 0; i < 200; i++) begin
            apply8("rand8", 8'($urandom_range(0, 255)));
        end

        // Narrow instance.
        apply4("w4_1010", 4'b1010);
        check("w4_1010.lit", 32'(out4), 32'h2);
        check("w4_1010.mlit", 32'(multi4), 32'h1);
        for (int v = 0; v < 16; v++) begin
            apply4("w4_sweep", 4'(v));
        end
        for (int i = 0; i < 50; i++) begin
            apply4("w4_rand", 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
